// File: rtl/mem_responder.sv
// Purpose : single-port byte memory answering a CPU WMFC-style request with an MFC strobe.
// Latency : MFC is high in the cycle WAIT+1 after the accepting edge (WAIT=0 -> the very next cycle).
// Backpr. : enable is level-held by the CPU; one held request yields one access, re-arm needs one enable=0 edge.
//
// Ports:
//   CLK, rst_n          clock, asynchronous active-low reset
//   enable              memory request, held until MFC is seen
//   rnw, MAR, wdata     1=read/0=write, word address, write data; sampled when the request is accepted
//   MBR                 read data, holds last completed read
//   MFC                 one-cycle memory-function-complete strobe
//   err                 out-of-range access flag, valid while MFC=1 (only when MEM_BOUND_EN is defined)
//
// Optional feature: define MEM_BOUND_EN for bounds checking (address >= DEPTH -> err, no write,
// MBR loaded with 8'h00). Without it addresses wrap modulo DEPTH and err does not exist.
// AW is assumed to be at most 32; WAIT must lie in 0..15.
module mem_responder #(
    parameter int unsigned AW    = 8,
    parameter int unsigned DEPTH = 128,
    parameter int unsigned WAIT  = 2
) (
    input  logic          CLK,
    input  logic          rst_n,
    input  logic          enable,
    input  logic          rnw,
    input  logic [AW-1:0] MAR,
    input  logic [7:0]    wdata,
    output logic [7:0]    MBR,
`ifdef MEM_BOUND_EN
    output logic          err,
`endif
    output logic          MFC
);

    localparam int unsigned IW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [3:0]  WAIT_C = 4'(WAIT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2,
        HOLD = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic            rnw_q, rnw_d;
    logic [7:0]      wdata_q, wdata_d;
    logic [7:0]      mbr_q, mbr_d;
`ifdef MEM_BOUND_EN
    logic            err_q, err_d;
    logic            oob;
`endif

    logic [7:0]      mem_q [DEPTH];

    logic [AW-1:0]   acc_addr;
    logic            acc_rnw;
    logic [7:0]      acc_wdata;
    logic [31:0]     acc_addr_w;
    logic [IW-1:0]   mem_idx;
    logic            commit;
    logic            mem_we;

    // ------------------------------------------------------------------
    // State register (plus the request latches that travel with it)
    // ------------------------------------------------------------------
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
            rnw_q   <= 1'b1;
            wdata_q <= 8'h00;
            mbr_q   <= 8'h00;
`ifdef MEM_BOUND_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            rnw_q   <= rnw_d;
            wdata_q <= wdata_d;
            mbr_q   <= mbr_d;
`ifdef MEM_BOUND_EN
            err_q   <= err_d;
`endif
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        rnw_d   = rnw_q;
        wdata_d = wdata_q;
        case (state_q)
            IDLE: begin
                if (enable) begin
                    addr_d  = MAR;
                    rnw_d   = rnw;
                    wdata_d = wdata;
                    cnt_d   = WAIT_C;
                    state_d = (WAIT_C == 4'd0) ? DONE : BUSY;
                end
            end
            BUSY: begin
                // enable is deliberately ignored here: an accepted access always completes.
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = DONE;
                end
            end
            DONE:    state_d = HOLD;
            HOLD:    if (!enable) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Access datapath. The access commits on the edge that enters DONE.
    // With WAIT=0 that edge is the accepting edge itself, so in IDLE the
    // live request operands are used instead of the (not yet loaded) latches.
    // ------------------------------------------------------------------
    always_comb begin
        if (state_q == IDLE) begin
            acc_addr  = MAR;
            acc_rnw   = rnw;
            acc_wdata = wdata;
        end else begin
            acc_addr  = addr_q;
            acc_rnw   = rnw_q;
            acc_wdata = wdata_q;
        end
    end

    assign acc_addr_w = 32'(acc_addr);
    assign mem_idx    = IW'(acc_addr_w % DEPTH);
    assign commit     = (state_d == DONE);

`ifdef MEM_BOUND_EN
    assign oob    = (acc_addr_w >= DEPTH);
    // rst_n gating keeps a WAIT=0 write from landing on an edge while reset is held.
    assign mem_we = rst_n && commit && !acc_rnw && !oob;
`else
    assign mem_we = rst_n && commit && !acc_rnw;
`endif

    always_comb begin
        mbr_d = mbr_q;
`ifdef MEM_BOUND_EN
        err_d = err_q;
        if (commit) begin
            err_d = oob;
            if (acc_rnw) begin
                mbr_d = oob ? 8'h00 : mem_q[mem_idx];
            end
        end
`else
        if (commit && acc_rnw) begin
            mbr_d = mem_q[mem_idx];
        end
`endif
    end

    // Storage is intentionally not reset: contents survive rst_n.
    always_ff @(posedge CLK) begin
        if (mem_we) begin
            mem_q[mem_idx] <= acc_wdata;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    always_comb begin
        MFC = (state_q == DONE);
        MBR = mbr_q;
`ifdef MEM_BOUND_EN
        err = (state_q == DONE) && err_q;
`endif
    end

endmodule
